// File: rtl/lfsr_seq_pkg.sv
// Shared types and helpers for the LFSR hex-dump sequencer.
// Holds the FSM state enum, ASCII constants, nibble-to-ASCII conversion.
// LFSR_CRLF_EN selects a CR/LF terminator instead of a single space.
package lfsr_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      STEP,
      CAPTURE,
      SEND,
      TERM
   } state_t;

   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_SPACE = 8'h20;

`ifdef LFSR_CRLF_EN
   localparam logic [7:0] TERM_FIRST = ASCII_CR;
`else
   localparam logic [7:0] TERM_FIRST = ASCII_SPACE;
`endif

   // 0-9 -> '0'-'9', 10-15 -> 'A'-'F'
   function automatic logic [7:0] nib2ascii(input logic [3:0] n);
      if (n < 4'd10)
         return 8'h30 + {4'h0, n};
      else
         return 8'h37 + {4'h0, n};
   endfunction

   // Nibble i of a 16-bit word, i=0 being the most significant
   function automatic logic [3:0] nib_sel(input logic [15:0] v,
                                          input logic [1:0]  i);
      logic [3:0] r;
      unique case (i)
         2'd0:    r = v[15:12];
         2'd1:    r = v[11:8];
         2'd2:    r = v[7:4];
         default: r = v[3:0];
      endcase
      return r;
   endfunction

endpackage

// File: rtl/lfsr_tx_sequencer_tick.sv
// Sample-period tick generator (module lfsr_tick_gen).
// Ports: CLK50MHZ, reset_n (async low), run (enable), tick (1-cycle pulse).
module lfsr_tick_gen #(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic CLK50MHZ,
   input  logic reset_n,
   input  logic run,
   output logic tick
);

   localparam int CW = $clog2(TICK_DIV);
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   // Tick is asserted in the last count cycle so the state machine
   // reacts on the wrap edge, TICK_DIV edges after run rises.
   assign tick = run && (cnt == LAST);

   always_ff @(posedge CLK50MHZ or negedge reset_n) begin
      if (!reset_n)
         cnt <= '0;
      else if (!run)
         cnt <= '0;
      else if (cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/lfsr_tx_sequencer.sv
// Periodically steps an external LFSR, captures it and sends it as four
// uppercase hex ASCII bytes plus a terminator over a valid/ready link.
// Ports: CLK50MHZ, reset_n, run, lfsr_q in; lfsr_step, tx_data, tx_valid out;
// tx_ready in; disp_value, busy, overrun out.
// LFSR_CRLF_EN: terminator CR LF (6 bytes/frame), else a space (5 bytes).
module lfsr_tx_sequencer
   import lfsr_seq_pkg::*;
#(
   parameter int TICK_DIV = 50_000_000,
   parameter int LFSR_W   = 16
) (
   input  logic              CLK50MHZ,
   input  logic              reset_n,
   input  logic              run,
   input  logic [LFSR_W-1:0] lfsr_q,
   output logic              lfsr_step,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic [LFSR_W-1:0] disp_value,
   output logic              busy,
   output logic              overrun
);

   state_t            state;
   logic [LFSR_W-1:0] shadow;
   logic [1:0]        idx;
   logic              tick;
   logic              accept;

   assign accept = tx_valid && tx_ready;

   lfsr_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .CLK50MHZ (CLK50MHZ),
      .reset_n  (reset_n),
      .run      (run),
      .tick     (tick)
   );

   always_ff @(posedge CLK50MHZ or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         lfsr_step  <= 1'b0;
         tx_data    <= 8'h00;
         tx_valid   <= 1'b0;
         disp_value <= '0;
         busy       <= 1'b0;
         overrun    <= 1'b0;
         shadow     <= '0;
         idx        <= 2'd0;
      end else begin
         // A tick that lands mid-frame is dropped but remembered
         if (tick && state != IDLE)
            overrun <= 1'b1;

         unique case (state)
            IDLE: begin
               if (tick) begin
                  state     <= STEP;
                  lfsr_step <= 1'b1;
                  busy      <= 1'b1;
               end
            end
            STEP: begin
               lfsr_step <= 1'b0;
               state     <= CAPTURE;
            end
            CAPTURE: begin
               shadow     <= lfsr_q;
               disp_value <= lfsr_q;
               tx_data    <= nib2ascii(nib_sel(lfsr_q, 2'd0));
               tx_valid   <= 1'b1;
               idx        <= 2'd0;
               state      <= SEND;
            end
            SEND: begin
               if (accept) begin
                  if (idx == 2'd3) begin
                     tx_data <= TERM_FIRST;
                     state   <= TERM;
                  end else begin
                     idx     <= idx + 2'd1;
                     tx_data <= nib2ascii(nib_sel(shadow, idx + 2'd1));
                  end
               end
            end
            TERM: begin
               if (accept) begin
`ifdef LFSR_CRLF_EN
                  if (tx_data == ASCII_CR) begin
                     tx_data <= ASCII_LF;
                  end else begin
                     tx_data  <= 8'h00;
                     tx_valid <= 1'b0;
                     busy     <= 1'b0;
                     state    <= IDLE;
                  end
`else
                  tx_data  <= 8'h00;
                  tx_valid <= 1'b0;
                  busy     <= 1'b0;
                  state    <= IDLE;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lfsr_tx_sequencer.sv
// Directed self-checking bench for lfsr_tx_sequencer.
// Honours LFSR_CRLF_EN for the expected terminator bytes.
module tb_lfsr_tx_sequencer;

   logic        clk = 1'b0;
   always #10 clk = ~clk;

   // instance A: TICK_DIV = 100
   logic        rst_n, run, tx_ready;
   logic [15:0] lfsr_q;
   logic        lfsr_step, tx_valid, busy, overrun;
   logic [7:0]  tx_data;
   logic [15:0] disp_value;

   // instance B: TICK_DIV = 8, overrun scenario
   logic        rst_b, run_b, rdy_b;
   logic [15:0] q_b;
   logic        step_b, valid_b, busy_b, ovr_b;
   logic [7:0]  data_b;
   logic [15:0] disp_b;

   int ncmp = 0;
   int nerr = 0;

   lfsr_tx_sequencer #(.TICK_DIV(100), .LFSR_W(16)) dut (
      .CLK50MHZ   (clk),
      .reset_n    (rst_n),
      .run        (run),
      .lfsr_q     (lfsr_q),
      .lfsr_step  (lfsr_step),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .disp_value (disp_value),
      .busy       (busy),
      .overrun    (overrun)
   );

   lfsr_tx_sequencer #(.TICK_DIV(8), .LFSR_W(16)) dut_b (
      .CLK50MHZ   (clk),
      .reset_n    (rst_b),
      .run        (run_b),
      .lfsr_q     (q_b),
      .lfsr_step  (step_b),
      .tx_data    (data_b),
      .tx_valid   (valid_b),
      .tx_ready   (rdy_b),
      .disp_value (disp_b),
      .busy       (busy_b),
      .overrun    (ovr_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Called at the negedge where run/reset_n just enabled counting;
   // lfsr_step must appear exactly n edges later, for one cycle.
   task automatic wait_step(input string tag, input int n);
      logic early;
      early = 1'b0;
      for (int i = 1; i < n; i++) begin
         @(negedge clk);
         if (lfsr_step) early = 1'b1;
      end
      @(negedge clk);
      chk({tag, "_early"}, 32'(early), 32'd0);
      chk({tag, "_at"}, 32'(lfsr_step), 32'd1);
      @(negedge clk);
      chk({tag, "_once"}, 32'(lfsr_step), 32'd0);
   endtask

   task automatic expect_byte(input string tag, input logic [7:0] exp);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!tx_valid && n < 400);
      chk({tag, "_valid"}, 32'(tx_valid), 32'd1);
      chk(tag, 32'(tx_data), 32'(exp));
   endtask

   task automatic expect_term(input string tag);
`ifdef LFSR_CRLF_EN
      expect_byte({tag, "_cr"}, 8'h0D);
      expect_byte({tag, "_lf"}, 8'h0A);
`else
      expect_byte({tag, "_sp"}, 8'h20);
`endif
      @(negedge clk);
      chk({tag, "_idle_valid"}, 32'(tx_valid), 32'd0);
      chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int  nst;
      logic stable;

      rst_n    = 1'b0;
      run      = 1'b0;
      tx_ready = 1'b1;
      lfsr_q   = 16'hACE1;
      rst_b    = 1'b0;
      run_b    = 1'b0;
      rdy_b    = 1'b0;
      q_b      = 16'hACE1;

      repeat (2) @(negedge clk);
      chk("rst_step", 32'(lfsr_step), 32'd0);
      chk("rst_valid", 32'(tx_valid), 32'd0);
      chk("rst_data", 32'(tx_data), 32'h00);
      chk("rst_disp", 32'(disp_value), 32'h0000);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ovr", 32'(overrun), 32'd0);

      // basic frame, step 100 edges after run rises
      rst_n = 1'b1;
      run   = 1'b1;
      wait_step("f1_step", 100);
      chk("f1_busy", 32'(busy), 32'd1);
      expect_byte("f1_b1", 8'h41);
      expect_byte("f1_b2", 8'h43);
      expect_byte("f1_b3", 8'h45);
      expect_byte("f1_b4", 8'h31);
      chk("f1_disp", 32'(disp_value), 32'hACE1);
      expect_term("f1");

      // backpressure on the second byte
      expect_byte("f2_b1", 8'h41);
      expect_byte("f2_b2", 8'h43);
      tx_ready = 1'b0;
      stable = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (!(tx_valid === 1'b1 && tx_data === 8'h43)) stable = 1'b0;
      end
      chk("f2_stall", 32'(stable), 32'd1);
      tx_ready = 1'b1;
      expect_byte("f2_b3", 8'h45);
      expect_byte("f2_b4", 8'h31);
      expect_term("f2");
      chk("f2_ovr", 32'(overrun), 32'd0);

      // run dropped mid-frame
      expect_byte("f3_b1", 8'h41);
      expect_byte("f3_b2", 8'h43);
      expect_byte("f3_b3", 8'h45);
      run = 1'b0;
      expect_byte("f3_b4", 8'h31);
      expect_term("f3");
      nst = 0;
      repeat (1000) begin
         @(negedge clk);
         if (lfsr_step) nst++;
      end
      chk("f3_nostep", 32'(nst), 32'd0);

      // reset in SEND, then digits-only value after release
      run = 1'b1;
      expect_byte("f4_b1", 8'h41);
      rst_n = 1'b0;
      #1;
      chk("r_step", 32'(lfsr_step), 32'd0);
      chk("r_valid", 32'(tx_valid), 32'd0);
      chk("r_data", 32'(tx_data), 32'h00);
      chk("r_disp", 32'(disp_value), 32'h0000);
      chk("r_busy", 32'(busy), 32'd0);
      chk("r_ovr", 32'(overrun), 32'd0);
      lfsr_q = 16'h0009;
      @(negedge clk);
      rst_n = 1'b1;
      wait_step("f5_step", 100);
      expect_byte("f5_b1", 8'h30);
      expect_byte("f5_b2", 8'h30);
      expect_byte("f5_b3", 8'h30);
      expect_byte("f5_b4", 8'h39);
      chk("f5_disp", 32'(disp_value), 32'h0009);
      expect_term("f5");

      // overrun with a short period and a stalled link
      @(negedge clk);
      rst_b = 1'b1;
      run_b = 1'b1;
      nst = 0;
      for (int i = 1; i <= 15; i++) begin
         @(negedge clk);
         if (step_b) nst++;
      end
      chk("ov_pre", 32'(ovr_b), 32'd0);
      chk("ov_valid", 32'(valid_b), 32'd1);
      chk("ov_data", 32'(data_b), 32'h41);
      chk("ov_disp", 32'(disp_b), 32'hACE1);
      @(negedge clk);
      if (step_b) nst++;
      chk("ov_set", 32'(ovr_b), 32'd1);
      repeat (40) begin
         @(negedge clk);
         if (step_b) nst++;
      end
      chk("ov_steps", 32'(nst), 32'd1);
      chk("ov_sticky", 32'(ovr_b), 32'd1);
      rst_b = 1'b0;
      #1;
      chk("ov_clr", 32'(ovr_b), 32'd0);
      chk("ov_busy", 32'(busy_b), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
